// File: rtl/control_parser_if.sv
// control_parser_if: byte stream from uart_rx into the command parser
// Ports:
//   rx_data    received byte, valid when rx_valid=1
//   rx_valid   one-cycle strobe per received byte
//   rx_invalid framing error flag, qualified by rx_valid
// Modports: master (uart_rx side), slave (parser side)
interface control_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_invalid;
  modport master (output rx_data, rx_valid, rx_invalid);
  modport slave  (input rx_data, rx_valid, rx_invalid);
endinterface

// File: rtl/control_parser.sv
// control_parser: ASCII command parser driving per-channel enables and levels
// Ports:
//   clk_in     system clock
//   reset_n    asynchronous active-low reset
//   rx         control_parser_if.slave byte stream (rx_data/rx_valid/rx_invalid)
//   enable     per-channel enable, bit i = channel i
//   level      channel i level at [i*LEVEL_WIDTH +: LEVEL_WIDTH]
//   busy       parser is mid-command
//   cmd_error  one-cycle error pulse
// Optional: define CONTROL_PARSER_LEGACY_RGB_EN for single-byte R/G/B/r/g/b commands.
module control_parser #(
  parameter int CHANNELS       = 3,
  parameter int LEVEL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 70000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic                            clk_in,
  input  logic                            reset_n,
  control_parser_if.slave                 rx,
  output logic [CHANNELS-1:0]             enable,
  output logic [CHANNELS*LEVEL_WIDTH-1:0] level,
  output logic                            busy,
  output logic                            cmd_error
);
  typedef enum logic [1:0] {IDLE, GET_CH, GET_HI, GET_LO} state_t;
  state_t                   state;
  logic [7:0]               op;
  logic [3:0]               ch;
  logic [3:0]               hi;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [7:0]               d;
  logic                     is_dig;
  logic                     is_hex;
  logic                     ch_ok;
  logic [3:0]               dig;
  logic [3:0]               hex;
  logic [7:0]               byte_val;
  logic [LEVEL_WIDTH-1:0]   new_lvl;
  logic                     tmo;
  logic                     rgb_hit;
  logic                     rgb_set;
  logic [1:0]               rgb_idx;
  assign d        = rx.rx_data;
  assign is_dig   = d >= "0" && d <= "9";
  assign dig      = d[3:0];
  assign ch_ok    = is_dig && int'(dig) < CHANNELS;
  assign is_hex   = is_dig || (d >= "A" && d <= "F") || (d >= "a" && d <= "f");
  // 'A'..'F' and 'a'..'f' both have low nibble 1..6
  assign hex      = is_dig ? dig : d[3:0] + 4'd9;
  assign byte_val = {hi, hex};
  assign new_lvl  = byte_val[7 -: LEVEL_WIDTH];
  assign tmo      = cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
`ifdef CONTROL_PARSER_LEGACY_RGB_EN
  assign rgb_hit  = d inside {"R", "G", "B", "r", "g", "b"};
  assign rgb_set  = !d[5];
  assign rgb_idx  = (d | 8'h20) == "r" ? 2'd0 : (d | 8'h20) == "g" ? 2'd1 : 2'd2;
`else
  assign rgb_hit  = 1'b0;
  assign rgb_set  = 1'b0;
  assign rgb_idx  = 2'd0;
`endif
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      enable    <= '1;
      level     <= '1;
      busy      <= 1'b0;
      cmd_error <= 1'b0;
      op        <= '0;
      ch        <= '0;
      hi        <= '0;
      cnt       <= '0;
    end else begin
      cmd_error <= 1'b0;
      if (rx.rx_valid) begin
        cnt <= '0;
        if (rx.rx_invalid) begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_error <= state != IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (d == "E" || d == "D" || d == "L") begin
                op    <= d;
                state <= GET_CH;
                busy  <= 1'b1;
              end else if (d == "X") begin
                enable <= '1;
                level  <= '1;
              end else if (rgb_hit) begin
                // letters mapping past the last channel match no index and are dropped
                for (int i = 0; i < CHANNELS; i++)
                  if (i == int'(rgb_idx)) enable[i] <= rgb_set;
              end
            end
            GET_CH: begin
              state     <= ch_ok && op == "L" ? GET_HI : IDLE;
              busy      <= ch_ok && op == "L";
              cmd_error <= !ch_ok;
              ch        <= dig;
              if (ch_ok && op != "L")
                for (int i = 0; i < CHANNELS; i++)
                  if (i == int'(dig)) enable[i] <= op == "E";
            end
            GET_HI: begin
              state     <= is_hex ? GET_LO : IDLE;
              busy      <= is_hex;
              cmd_error <= !is_hex;
              hi        <= hex;
            end
            default: begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_error <= !is_hex;
              if (is_hex)
                for (int i = 0; i < CHANNELS; i++)
                  if (i == int'(ch)) level[i*LEVEL_WIDTH +: LEVEL_WIDTH] <= new_lvl;
            end
          endcase
        end
      end else if (state != IDLE) begin
        if (tmo) begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_error <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_control_parser.sv
// tb_control_parser: scoreboard bench for control_parser (8-bit and 4-bit level builds side by side)
module tb_control_parser;
  localparam int T = 12;
  localparam logic [23:0] FF = 24'hFFFFFF;
  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  en_a, en_b;
  logic [23:0] lv_a;
  logic [11:0] lv_b;
  logic        busy_a, busy_b, err_a, err_b;
  int          checks = 0;
  int          failures = 0;
  control_parser_if bus();
  control_parser #(.CHANNELS(3), .LEVEL_WIDTH(8), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) u_a (
    .clk_in(clk_in), .reset_n(reset_n), .rx(bus), .enable(en_a), .level(lv_a), .busy(busy_a), .cmd_error(err_a));
  control_parser #(.CHANNELS(3), .LEVEL_WIDTH(4), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) u_b (
    .clk_in(clk_in), .reset_n(reset_n), .rx(bus), .enable(en_b), .level(lv_b), .busy(busy_b), .cmd_error(err_b));
  always #5 clk_in = ~clk_in;
  typedef struct packed {
    logic [7:0]  b;
    logic        inv;
    logic        idle;
    logic [2:0]  en;
    logic [23:0] lv;
    logic        busy;
    logic        err;
  } step_t;
  step_t q[$];
  function automatic step_t mk(logic [7:0] bt, logic inv, logic idle, logic [2:0] en, logic [23:0] lv, logic bz, logic er);
    return {bt, inv, idle, en, lv, bz, er};
  endfunction
  function automatic logic [45:0] obs();
    return {en_a, lv_a, busy_a, err_a, en_b, lv_b, busy_b, err_b};
  endfunction
  function automatic logic [45:0] want(step_t e);
    return {e.en, e.lv, e.busy, e.err, e.en, e.lv[23:20], e.lv[15:12], e.lv[7:4], e.busy, e.err};
  endfunction
  task automatic drive(input step_t s);
    @(negedge clk_in);
    bus.rx_data    = s.b;
    bus.rx_valid   = !s.idle;
    bus.rx_invalid = s.inv;
    q.push_back(s);
    @(posedge clk_in);
    #1;
    bus.rx_valid   = 1'b0;
    bus.rx_invalid = 1'b0;
  endtask
  task automatic test_reset();
    step_t e;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_invalid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    q.push_back(mk(8'h00, 0, 1, 3'b111, FF, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== want(e)) begin failures++; $display("FAIL reset: got=%h want=%h", obs(), want(e)); end
    @(negedge clk_in) reset_n = 1'b1;
    drive(mk(8'h00, 0, 1, 3'b111, FF, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== want(e)) begin failures++; $display("FAIL reset_release: got=%h want=%h", obs(), want(e)); end
  endtask
  task automatic test_disable();
    step_t s[$], e;
    s.push_back(mk("D", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("1", 0, 0, 3'b101, FF, 0, 0));
    s.push_back(mk(8'h0, 0, 1, 3'b101, FF, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL disable step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  task automatic test_level_b2b();
    step_t s[$], e;
    s.push_back(mk("L", 0, 0, 3'b101, FF, 1, 0));
    s.push_back(mk("2", 0, 0, 3'b101, FF, 1, 0));
    s.push_back(mk("7", 0, 0, 3'b101, FF, 1, 0));
    s.push_back(mk("f", 0, 0, 3'b101, 24'h7FFFFF, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL level_b2b step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  task automatic test_level_narrow();
    step_t s[$], e;
    s.push_back(mk("L", 0, 0, 3'b101, 24'h7FFFFF, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b101, 24'h7FFFFF, 1, 0));
    s.push_back(mk("C", 0, 0, 3'b101, 24'h7FFFFF, 1, 0));
    s.push_back(mk("3", 0, 0, 3'b101, 24'h7FFFC3, 0, 0));
    s.push_back(mk("E", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk("5", 0, 0, 3'b101, 24'h7FFFC3, 0, 1));
    s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL level_narrow step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  task automatic test_timeout();
    step_t s[$], e;
    s.push_back(mk("L", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk("1", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    for (int k = 1; k < T; k++) s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 0, 1));
    s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 0, 0));
    s.push_back(mk("A", 0, 0, 3'b101, 24'h7FFFC3, 0, 0));
    s.push_back(mk("L", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk("1", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    for (int k = 1; k < T; k++) s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk("3", 0, 0, 3'b101, 24'h7FFFC3, 1, 0));
    for (int k = 1; k < T; k++) s.push_back(mk(8'h0, 0, 1, 3'b101, 24'h7FFFC3, 1, 0));
    s.push_back(mk("4", 0, 0, 3'b101, 24'h7F34C3, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL timeout step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  task automatic test_invalid();
    step_t s[$], e;
    s.push_back(mk("L", 0, 0, 3'b101, 24'h7F34C3, 1, 0));
    s.push_back(mk("0", 1, 0, 3'b101, 24'h7F34C3, 0, 1));
    s.push_back(mk("E", 0, 0, 3'b101, 24'h7F34C3, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b101, 24'h7F34C3, 0, 0));
    s.push_back(mk("E", 1, 0, 3'b101, 24'h7F34C3, 0, 0));
    s.push_back(mk("D", 0, 0, 3'b101, 24'h7F34C3, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b100, 24'h7F34C3, 0, 0));
    s.push_back(mk("L", 0, 0, 3'b100, 24'h7F34C3, 1, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL invalid step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
    #2 reset_n = 1'b0;
    #1 q.push_back(mk(8'h0, 0, 1, 3'b111, FF, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== want(e)) begin failures++; $display("FAIL async_reset: got=%h want=%h", obs(), want(e)); end
    @(negedge clk_in) reset_n = 1'b1;
  endtask
  task automatic test_legacy();
    step_t s[$], e;
    s.push_back(mk("L", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("B", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("b", 0, 0, 3'b111, 24'hFFFFBB, 0, 0));
`ifdef CONTROL_PARSER_LEGACY_RGB_EN
    s.push_back(mk("g", 0, 0, 3'b101, 24'hFFFFBB, 0, 0));
    s.push_back(mk("R", 0, 0, 3'b101, 24'hFFFFBB, 0, 0));
    s.push_back(mk("r", 0, 0, 3'b100, 24'hFFFFBB, 0, 0));
`else
    s.push_back(mk("g", 0, 0, 3'b111, 24'hFFFFBB, 0, 0));
    s.push_back(mk("E", 0, 0, 3'b111, 24'hFFFFBB, 1, 0));
    s.push_back(mk("B", 0, 0, 3'b111, 24'hFFFFBB, 0, 1));
`endif
    s.push_back(mk("X", 0, 0, 3'b111, FF, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL legacy step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  task automatic test_back_to_back();
    step_t s[$], e;
    s.push_back(mk("D", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("2", 0, 0, 3'b011, FF, 0, 0));
    s.push_back(mk("E", 0, 0, 3'b011, FF, 1, 0));
    s.push_back(mk("2", 0, 0, 3'b111, FF, 0, 0));
    s.push_back(mk("D", 0, 0, 3'b111, FF, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b110, FF, 0, 0));
    s.push_back(mk("L", 0, 0, 3'b110, FF, 1, 0));
    s.push_back(mk("1", 0, 0, 3'b110, FF, 1, 0));
    s.push_back(mk("8", 0, 0, 3'b110, FF, 1, 0));
    s.push_back(mk("0", 0, 0, 3'b110, 24'hFF80FF, 0, 0));
    s.push_back(mk("L", 0, 0, 3'b110, 24'hFF80FF, 1, 0));
    s.push_back(mk("2", 0, 0, 3'b110, 24'hFF80FF, 1, 0));
    s.push_back(mk("G", 0, 0, 3'b110, 24'hFF80FF, 0, 1));
    s.push_back(mk("X", 0, 0, 3'b111, FF, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      e = q.pop_front(); checks++;
      if (obs() !== want(e)) begin failures++; $display("FAIL back_to_back step %0d: got=%h want=%h", i, obs(), want(e)); end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_disable();
    test_level_b2b();
    test_level_narrow();
    test_timeout();
    test_invalid();
    test_legacy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
